// File: rtl/keypad_press_emulator.sv
// rtl/keypad_press_emulator.sv - key matrix emulator turning a two-digit guess into timed key and button presses
module keypad_press_emulator #(
    parameter int HOLD_CYCLES   = 50000,
    parameter int GAP_CYCLES    = 50000,
    parameter int BOUNCE_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypadRow,
    output logic [3:0] keypadCol,
    output logic       button_out,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_guess,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRESS_T, S_GAP_T, S_PRESS_U, S_GAP_U, S_PRESS_B, S_GAP_B, S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_tens;
    logic [3:0]      r_units;
    logic            r_err;

    logic            w_accept;
    logic            w_in_range;
    logic [3:0]      w_tens;
    logic [3:0]      w_units;
    logic [3:0]      w_digit;
    logic [1:0]      w_row;
    logic [1:0]      w_col;
    logic            w_bouncing;
    logic            w_closed;
    logic            w_key_phase;

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIN);
    assign err        = r_err;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_in_range = (cmd_guess <= 7'd99);

    // Tens digit by threshold chain; units are then exact modulo 16 because they are below 10
    always_comb begin
        w_tens = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            if (cmd_guess >= 7'(10 * k)) begin
                w_tens = 4'(k);
            end
        end
        w_units = cmd_guess[3:0] - (w_tens * 4'd10);
    end

    // Chatter only exists when a bounce window is configured: odd indices inside it read open
    generate
        if (BOUNCE_CYCLES > 0) begin : g_bounce
            localparam logic [CW-1:0] BOUNCE_W = CW'(BOUNCE_CYCLES);
            assign w_bouncing = (r_cnt < BOUNCE_W) && r_cnt[0];
        end else begin : g_no_bounce
            assign w_bouncing = 1'b0;
        end
    endgenerate

    assign w_closed    = !w_bouncing;
    assign w_key_phase = (r_state == S_PRESS_T) || (r_state == S_PRESS_U);
    assign w_digit     = (r_state == S_PRESS_U) ? r_units : r_tens;
    assign button_out  = (r_state == S_PRESS_B) && w_closed;

    // Map the active digit onto its row/column crossing in the 4x4 matrix
    always_comb begin
        w_row = 2'd3;
        w_col = 2'd1;
        case (w_digit)
            4'd1: begin w_row = 2'd0; w_col = 2'd0; end
            4'd2: begin w_row = 2'd0; w_col = 2'd1; end
            4'd3: begin w_row = 2'd0; w_col = 2'd2; end
            4'd4: begin w_row = 2'd1; w_col = 2'd0; end
            4'd5: begin w_row = 2'd1; w_col = 2'd1; end
            4'd6: begin w_row = 2'd1; w_col = 2'd2; end
            4'd7: begin w_row = 2'd2; w_col = 2'd0; end
            4'd8: begin w_row = 2'd2; w_col = 2'd1; end
            4'd9: begin w_row = 2'd2; w_col = 2'd2; end
            default: begin w_row = 2'd3; w_col = 2'd1; end
        endcase
    end

    // Pull the pressed key's column low only while the scanner strobes its row
    always_comb begin
        keypadCol = 4'b1111;
        if (w_key_phase && w_closed && !keypadRow[w_row]) begin
            keypadCol[w_col] = 1'b0;
        end
    end

    // Next-state: fixed-length press and release phases for tens, units and confirm
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept && w_in_range) w_state_next = S_PRESS_T;
            S_PRESS_T: if (r_cnt == HOLD_LAST) w_state_next = S_GAP_T;
            S_GAP_T:   if (r_cnt == GAP_LAST)  w_state_next = S_PRESS_U;
            S_PRESS_U: if (r_cnt == HOLD_LAST) w_state_next = S_GAP_U;
            S_GAP_U:   if (r_cnt == GAP_LAST)  w_state_next = S_PRESS_B;
            S_PRESS_B: if (r_cnt == HOLD_LAST) w_state_next = S_GAP_B;
            S_GAP_B:   if (r_cnt == GAP_LAST)  w_state_next = S_FIN;
            S_FIN:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // State, shared phase counter (restarts on every state change), latched digits and reject pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_accept && !w_in_range;
            if (w_state_next != r_state || r_state == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept && w_in_range) begin
                r_tens  <= w_tens;
                r_units <= w_units;
            end
        end
    end

endmodule
